// File: rtl/e_mdu_pkg.sv
// Shared types for the execute-stage multiply/divide unit: opcode and FSM
// state encodings plus the start-decode helper.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    function automatic logic is_md_start(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage <-> MDU signal bundle: operands/opcode in, HI/LO, read data and
// stall request out.
interface e_mdu_if;
    import e_mdu_pkg::*;

    logic        valid;
    mdu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    modport master (
        output valid, op, a, b,
        input  busy, md_stall, hi, lo, mf_data
    );

    modport slave (
        input  valid, op, a, b,
        output busy, md_stall, hi, lo, mf_data
    );

endinterface

// File: rtl/e_mdu.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; the result is computed
// at start and held in hi_tmp/lo_tmp until the fixed latency expires.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    e_mdu_if.slave   bus
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_e         r_state;
    mdu_state_e         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_hi_tmp;
    logic [31:0]        r_lo_tmp;

    logic               w_idle;
    logic               w_start;
    logic               w_is_mul;
    logic               w_done;
    logic               w_idle_wr;
    logic signed [63:0] w_a_s;
    logic signed [63:0] w_b_s;
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic        [63:0] w_sdiv;
    logic        [31:0] w_res_hi;
    logic        [31:0] w_res_lo;

    // Signed divide via magnitudes: avoids the 0x80000000 / -1 overflow trap of
    // a native signed divide and yields LO=0x80000000, HI=0 for that case.
    function automatic logic [63:0] sdiv(input logic [31:0] n, input logic [31:0] d);
        logic [31:0] n_mag, d_mag, q_mag, r_mag, q, r;
        n_mag = n[31] ? (~n + 32'd1) : n;
        d_mag = d[31] ? (~d + 32'd1) : d;
        q_mag = n_mag / d_mag;
        r_mag = n_mag % d_mag;
        q     = (n[31] ^ d[31]) ? (~q_mag + 32'd1) : q_mag;
        r     = n[31] ? (~r_mag + 32'd1) : r_mag;
        return {r, q};
    endfunction

    assign w_idle    = (r_state == ST_IDLE);
    assign w_start   = bus.valid && is_md_start(bus.op) && w_idle;
    assign w_is_mul  = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign w_done    = !w_idle && (r_cnt == CNT_W'(1));
    assign w_idle_wr = bus.valid && w_idle;

    assign w_a_s    = {{32{bus.a[31]}}, bus.a};
    assign w_b_s    = {{32{bus.b[31]}}, bus.b};
    assign w_prod_s = w_a_s * w_b_s;
    assign w_prod_u = {32'd0, bus.a} * {32'd0, bus.b};
    assign w_sdiv   = sdiv(bus.a, bus.b);

    // A zero divisor latches the current HI/LO, so completion leaves them unchanged.
    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (bus.op)
            OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            OP_DIV: begin
                if (bus.b != 32'd0) {w_res_hi, w_res_lo} = w_sdiv;
            end
            OP_DIVU: begin
                if (bus.b != 32'd0) begin
                    w_res_lo = bus.a / bus.b;
                    w_res_hi = bus.a % bus.b;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = w_is_mul ? ST_MUL : ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                if (r_cnt == CNT_W'(1)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_hi_tmp <= '0;
            r_lo_tmp <= '0;
        end else begin
            if (w_start) begin
                r_cnt    <= w_is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                r_hi_tmp <= w_res_hi;
                r_lo_tmp <= w_res_lo;
            end else if (!w_idle) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_done) begin
                r_hi <= r_hi_tmp;
                r_lo <= r_lo_tmp;
            end else if (w_idle_wr) begin
                if (bus.op == OP_MTHI) r_hi <= bus.a;
                if (bus.op == OP_MTLO) r_lo <= bus.a;
            end
        end
    end

    always_comb begin
        bus.busy     = !w_idle;
        bus.md_stall = !w_idle || (bus.valid && is_md_start(bus.op));
        bus.hi       = r_hi;
        bus.lo       = r_lo;
        case (bus.op)
            OP_MFHI: bus.mf_data = r_hi;
            OP_MFLO: bus.mf_data = r_lo;
            default: bus.mf_data = 32'd0;
        endcase
    end

endmodule
